genevr_ctrl_regs: RTL
=====================

GENEVR_CTRL_REGS -- requirements
Module: genevr_ctrl_regs

Interface
REQ-001 SHALL have parameter AXI_DATA_WIDTH, default 32: register and data width.
REQ-002 SHALL have parameter AXI_ADDR_WIDTH, default 26: request address width.
REQ-003 SHALL have parameter REG_ADDR_WIDTH, default 8: in-block word offset width; bits [REG_ADDR_WIDTH-1:REG_ADDR_WIDTH-2] are the region, the low bits are the index.
REQ-004 SHALL have parameter BLOCK_ADDR, default 18'h10017: tag that reg_addr_in[AXI_ADDR_WIDTH-1:REG_ADDR_WIDTH] must equal.
REQ-005 SHALL have parameter NUM_CTRL_REG, default 4: number of RW control registers.
REQ-006 SHALL have parameter NUM_EVT, default 8: number of event inputs, legal range 1..AXI_DATA_WIDTH.
REQ-007 SHALL have port clk  in  1: single clock.
REQ-008 SHALL have port reset_n  in  1: reset, asynchronous assert, active-low.
REQ-009 SHALL have ports reg_req_in (in, 1, request strobe), reg_rd_wr_L_in (in, 1, 1=read 0=write), reg_addr_in (in, AXI_ADDR_WIDTH, word address) and reg_wr_data (in, AXI_DATA_WIDTH, write data).
REQ-010 SHALL have ports reg_ack_out (out, 1, one-cycle acknowledge) and reg_rd_data (out, AXI_DATA_WIDTH, read data, valid while ack is high).
REQ-011 SHALL have port ctrl_regs  out  AXI_DATA_WIDTH*NUM_CTRL_REG: flattened control registers, reg i at bits [W*(i+1)-1:W*i].
REQ-012 SHALL have port evt_in  in  NUM_EVT: level event/status inputs, synchronous to clk.
REQ-013 SHALL have port irq_out  out  1: registered interrupt.

Function
REQ-014 Region map SHALL be: 00 control RW, index < NUM_CTRL_REG; 01 status, where idx0 = live evt_in (RO), idx1 = sticky (W1C) and idx2 = irq_mask (RW); 10 reserved; 11 event counters, index < NUM_EVT, read gives the count and any write clears it.
REQ-015 A request SHALL be accepted in any cycle with reg_req_in=1 and tag hit; reg_ack_out SHALL pulse high exactly one cycle later, together with reg_rd_data for reads.
REQ-016 Back-to-back requests in consecutive cycles SHALL each be acknowledged, one ack per request, in order.
REQ-017 A tag miss SHALL produce no ack, no state change, and SHALL leave reg_rd_data holding its previous value.
REQ-018 Reads of the reserved region, or of an out-of-range index, SHALL ack with reg_rd_data=32'hDEAD_BEEF; writes to them SHALL ack and be ignored.
REQ-019 Writes to RO live status SHALL ack and be ignored; reads of sticky SHALL NOT clear it.
REQ-020 Edge detect SHALL register evt_in into evt_d; rise = evt_in & ~evt_d; the sticky bit and the counter SHALL update in the cycle after the rise is seen.
REQ-021 Sticky W1C in the same cycle as a new rise on the same bit SHALL leave the bit set (set wins).
REQ-022 Counters SHALL be AXI_DATA_WIDTH wide and saturate at all-ones with no wrap.
REQ-023 A counter clear in the same cycle as a rise on that event SHALL leave the counter at 1.
REQ-024 irq_out SHALL equal the registered |(sticky & irq_mask[NUM_EVT-1:0]), updating one cycle after sticky or mask changes.
REQ-025 Live, sticky and mask reads SHALL zero-fill bits at and above NUM_EVT.

Reset
REQ-026 While reset_n=0: reg_ack_out=0, reg_rd_data=0, irq_out=0, all control regs=0, sticky=0, irq_mask=0, counters=0 and evt_d=0.
REQ-027 A request in flight when reset asserts SHALL be dropped, with no ack after release.
REQ-028 An evt_in already high at reset release SHALL count as a rise in the first clock edge.

Structure
REQ-029 Package genevr_regs_pkg SHALL hold the region encodings (REGION_CTRL/STAT/RSVD/CNT), the status indices (STAT_LIVE=0, STAT_STICKY=1, STAT_MASK=2) and RD_BAD=32'hDEAD_BEEF.
REQ-030 Sub-module genevr_evt_counter SHALL implement one saturating counter with inc/clr inputs; it is instanced NUM_EVT times through a generate loop.

Verification
REQ-031 Write 0x1234_5678 to ctrl idx2, then read it: ack one cycle after each request, rd_data=0x1234_5678, ctrl_regs[95:64]=0x1234_5678.
REQ-032 Read the reserved region, then read ctrl idx NUM_CTRL_REG: both ack with 0xDEAD_BEEF; a tag-miss request gets no ack and rd_data unchanged.
REQ-033 Pulse evt_in[3] high for 5 cycles with mask=0x08: sticky=0x08, counter3=1, irq_out=1 two cycles after the rise; W1C 0x08 then gives sticky=0 and irq_out=0.
REQ-034 W1C of bit0 in the same cycle as a new rise on evt_in[0]: sticky bit0 stays 1; clearing counter0 in the same cycle as a rise: counter0=1.
REQ-035 Force counter5 to 0xFFFF_FFFE and apply 3 rises: reads give 0xFFFF_FFFF with no wrap.
REQ-036 Assert reset_n=0 mid-request after ctrl writes: all outputs 0 and no ack; after release, reading ctrl idx0 gives 0.

Source files
------------

// File: rtl/genevr_regs_pkg.sv
// genevr_regs_pkg: shared region/index encodings and bad-read pattern for the event register block
package genevr_regs_pkg;
   typedef enum logic [1:0] {
      REGION_CTRL = 2'b00,
      REGION_STAT = 2'b01,
      REGION_RSVD = 2'b10,
      REGION_CNT  = 2'b11
   } region_e;
   localparam int STAT_LIVE   = 0;
   localparam int STAT_STICKY = 1;
   localparam int STAT_MASK   = 2;
   localparam logic [31:0] RD_BAD = 32'hDEAD_BEEF;
endpackage

// File: rtl/genevr_evt_counter.sv
// genevr_evt_counter: one saturating event counter; a clear coinciding with an increment restarts at 1
module genevr_evt_counter
   import genevr_regs_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         i_inc,
   input  logic         i_clr,
   output logic [W-1:0] o_cnt
);
   logic [W-1:0] r_cnt;
   assign o_cnt = r_cnt;
   // count rises, hold at all-ones, clear takes precedence but keeps a same-cycle rise
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) r_cnt <= '0;
      else if (i_clr) r_cnt <= W'(i_inc);
      else if (i_inc && !(&r_cnt)) r_cnt <= r_cnt + W'(1);
endmodule

// File: rtl/genevr_ctrl_regs.sv
// genevr_ctrl_regs: control/status/event-counter register block with one-cycle ack and registered irq
module genevr_ctrl_regs
   import genevr_regs_pkg::*;
#(
   parameter int AXI_DATA_WIDTH = 32,
   parameter int AXI_ADDR_WIDTH = 26,
   parameter int REG_ADDR_WIDTH = 8,
   parameter logic [AXI_ADDR_WIDTH-REG_ADDR_WIDTH-1:0] BLOCK_ADDR = 18'h10017,
   parameter int NUM_CTRL_REG = 4,
   parameter int NUM_EVT = 8
) (
   input  logic                                   clk,
   input  logic                                   reset_n,
   input  logic                                   reg_req_in,
   input  logic                                   reg_rd_wr_L_in,
   input  logic [AXI_ADDR_WIDTH-1:0]              reg_addr_in,
   input  logic [AXI_DATA_WIDTH-1:0]              reg_wr_data,
   output logic                                   reg_ack_out,
   output logic [AXI_DATA_WIDTH-1:0]              reg_rd_data,
   output logic [AXI_DATA_WIDTH*NUM_CTRL_REG-1:0] ctrl_regs,
   input  logic [NUM_EVT-1:0]                     evt_in,
   output logic                                   irq_out
);
   localparam int W = AXI_DATA_WIDTH;
   logic [W-1:0]              r_ctrl [NUM_CTRL_REG];
   logic [NUM_EVT-1:0]        r_evt_d, r_sticky, r_mask;
   logic                      r_ack, r_irq;
   logic [W-1:0]              r_rd_data;
   logic [W-1:0]              w_cnt [NUM_EVT];
   logic [NUM_EVT-1:0]        w_rise, w_w1c, w_clr;
   logic                      w_hit, w_wr;
   region_e                   w_region;
   logic [REG_ADDR_WIDTH-3:0] w_idx;
   logic [W-1:0]              w_rd_val;
   assign w_hit    = reg_req_in && (reg_addr_in[AXI_ADDR_WIDTH-1:REG_ADDR_WIDTH] == BLOCK_ADDR);
   assign w_wr     = w_hit && !reg_rd_wr_L_in;
   assign w_region = region_e'(reg_addr_in[REG_ADDR_WIDTH-1:REG_ADDR_WIDTH-2]);
   assign w_idx    = reg_addr_in[REG_ADDR_WIDTH-3:0];
   assign w_rise   = evt_in & ~r_evt_d;
   assign w_w1c    = (w_wr && w_region == REGION_STAT && int'(w_idx) == STAT_STICKY) ? reg_wr_data[NUM_EVT-1:0] : '0;
   assign reg_ack_out = r_ack;
   assign reg_rd_data = r_rd_data;
   assign irq_out     = r_irq;
   for (genvar g = 0; g < NUM_CTRL_REG; g++) begin : g_flat
      assign ctrl_regs[g*W +: W] = r_ctrl[g];
   end
   for (genvar g = 0; g < NUM_EVT; g++) begin : g_cnt
      genevr_evt_counter #(.W(W)) u_cnt (
         .clk    (clk),
         .reset_n(reset_n),
         .i_inc  (w_rise[g]),
         .i_clr  (w_clr[g]),
         .o_cnt  (w_cnt[g])
      );
   end
   // read decode: anything not matched below returns the bad-address pattern; also decode counter clears
   always_comb begin
      w_rd_val = W'(RD_BAD);
      w_clr    = '0;
      for (int i = 0; i < NUM_CTRL_REG; i++)
         if (w_region == REGION_CTRL && int'(w_idx) == i) w_rd_val = r_ctrl[i];
      for (int i = 0; i < NUM_EVT; i++) begin
         if (w_region == REGION_CNT && int'(w_idx) == i) w_rd_val = w_cnt[i];
         w_clr[i] = w_wr && w_region == REGION_CNT && int'(w_idx) == i;
      end
      if (w_region == REGION_STAT)
         w_rd_val = (int'(w_idx) == STAT_LIVE)   ? W'(evt_in)   :
                    (int'(w_idx) == STAT_STICKY) ? W'(r_sticky) :
                    (int'(w_idx) == STAT_MASK)   ? W'(r_mask)   : W'(RD_BAD);
   end
   // response: ack every accepted request one cycle later; read data only moves on accepted reads
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         r_ack     <= 1'b0;
         r_rd_data <= '0;
      end else begin
         r_ack <= w_hit;
         if (w_hit && reg_rd_wr_L_in) r_rd_data <= w_rd_val;
      end
   // control registers: plain RW storage
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         for (int i = 0; i < NUM_CTRL_REG; i++) r_ctrl[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_CTRL_REG; i++)
            if (w_wr && w_region == REGION_CTRL && int'(w_idx) == i) r_ctrl[i] <= reg_wr_data;
      end
   // status: edge history, sticky with set-wins W1C, mask, and registered interrupt
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         r_evt_d  <= '0;
         r_sticky <= '0;
         r_mask   <= '0;
         r_irq    <= 1'b0;
      end else begin
         r_evt_d  <= evt_in;
         r_sticky <= (r_sticky & ~w_w1c) | w_rise;
         if (w_wr && w_region == REGION_STAT && int'(w_idx) == STAT_MASK) r_mask <= reg_wr_data[NUM_EVT-1:0];
         r_irq    <= |(r_sticky & r_mask);
      end
endmodule
